// File: rtl/pinball_collision_pkg.sv
// Shared constants for the pinball collision logic: collision class indices
// and smiley edge-code bit positions.
package pinball_collision_pkg;

  localparam int COLL_TOP      = 0;
  localparam int COLL_LEFT     = 1;
  localparam int COLL_RIGHT    = 2;
  localparam int COLL_FLIPPER  = 3;
  localparam int COLL_OBSTACLE = 4;
  localparam int NUM_COLL      = 5;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  typedef logic [NUM_COLL-1:0] coll_mask_t;

endpackage

// File: rtl/collision_once_per_frame.sv
// Per-class collision tracker: fires a single-cycle pulse on the first overlap
// of a frame and remembers that the class has already been reported.
module collision_once_per_frame (
  input  logic clk,
  input  logic resetN,
  input  logic hit,
  input  logic startOfFrame,
  input  logic pause,
  input  logic reset_level,
  output logic pulse,
  output logic seen
);

  logic seen_q, seen_d;
  logic pulse_q, pulse_d;

  // Priority: level restart, then pause (state frozen), then frame boundary.
  always_comb begin
    seen_d  = seen_q;
    pulse_d = 1'b0;
    if (reset_level) begin
      seen_d = 1'b0;
    end else if (pause) begin
      seen_d = seen_q;
    end else if (startOfFrame) begin
      seen_d = 1'b0;
    end else if (hit && !seen_q) begin
      seen_d  = 1'b1;
      pulse_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      seen_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      seen_q  <= seen_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
  assign seen  = seen_q;

endmodule

// File: rtl/smiley_collision_detector.sv
// Smiley collision detector: per-class once-per-frame pulses, obstacle edge
// code capture, per-frame collision summary and stuck-on-border alarm.
module smiley_collision_detector
  import pinball_collision_pkg::*;
#(
  parameter int STUCK_FRAMES = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       pause,
  input  logic       reset_level,
  input  logic       smileyDR,
  input  logic       borderTopDR,
  input  logic       borderLeftDR,
  input  logic       borderRightDR,
  input  logic       flipperDR,
  input  logic       obstacleDR,
  input  logic [3:0] obstacleHitEdgeCode,
  output logic       collisionSmileyBorderTop,
  output logic       collisionSmileyBorderLeft,
  output logic       collisionSmileyBorderRight,
  output logic       collisionSmileyFlipper,
  output logic       collisionSmileyObstacle,
  output logic [3:0] hitEdgeCode,
  output logic [4:0] frameCollisionMask,
  output logic       stuckAlarm
);

  localparam int CNT_W = $clog2(STUCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STUCK_FRAMES);

  coll_mask_t hit, seen, pulse;

  assign hit[COLL_TOP]      = smileyDR & borderTopDR;
  assign hit[COLL_LEFT]     = smileyDR & borderLeftDR;
  assign hit[COLL_RIGHT]    = smileyDR & borderRightDR;
  assign hit[COLL_FLIPPER]  = smileyDR & flipperDR;
  assign hit[COLL_OBSTACLE] = smileyDR & obstacleDR;

  for (genvar k = 0; k < NUM_COLL; k++) begin : gen_class
    collision_once_per_frame u_once (
      .clk          (clk),
      .resetN       (resetN),
      .hit          (hit[k]),
      .startOfFrame (startOfFrame),
      .pause        (pause),
      .reset_level  (reset_level),
      .pulse        (pulse[k]),
      .seen         (seen[k])
    );
  end

  assign collisionSmileyBorderTop   = pulse[COLL_TOP];
  assign collisionSmileyBorderLeft  = pulse[COLL_LEFT];
  assign collisionSmileyBorderRight = pulse[COLL_RIGHT];
  assign collisionSmileyFlipper     = pulse[COLL_FLIPPER];
  assign collisionSmileyObstacle    = pulse[COLL_OBSTACLE];

  coll_mask_t      mask_q, mask_d, frameMask;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            alarm_q, alarm_d;
  logic [3:0]      edge_q, edge_d;
  logic            obstacleLoad;

  // Same condition under which the obstacle tracker fires its pulse.
  assign obstacleLoad = hit[COLL_OBSTACLE] & ~seen[COLL_OBSTACLE] &
                        ~startOfFrame & ~pause & ~reset_level;
  assign frameMask    = seen | hit;

  always_comb begin
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    edge_d  = edge_q;
    if (reset_level) begin
      mask_d  = '0;
      cnt_d   = '0;
      alarm_d = 1'b0;
      edge_d  = '0;
    end else if (pause) begin
      if (startOfFrame) mask_d = '0;
    end else begin
      if (obstacleLoad) edge_d = obstacleHitEdgeCode;
      if (startOfFrame) begin
        mask_d = frameMask;
        if (|frameMask[COLL_RIGHT:COLL_TOP]) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
        end
        alarm_d = (cnt_d == CNT_MAX);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mask_q  <= '0;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
      edge_q  <= '0;
    end else begin
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
      edge_q  <= edge_d;
    end
  end

  assign hitEdgeCode        = edge_q;
  assign frameCollisionMask = mask_q;
  assign stuckAlarm         = alarm_q;

endmodule

// File: tb/tb_smiley_collision_detector.sv
// Directed self-checking bench for smiley_collision_detector (STUCK_FRAMES = 8).
module tb_smiley_collision_detector;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame, pause, reset_level;
  logic       smileyDR, borderTopDR, borderLeftDR, borderRightDR, flipperDR, obstacleDR;
  logic [3:0] obstacleHitEdgeCode;
  logic       colTop, colLeft, colRight, colFlipper, colObstacle;
  logic [3:0] hitEdgeCode;
  logic [4:0] frameCollisionMask;
  logic       stuckAlarm;

  int testsRun = 0;
  int testsFailed = 0;

  smiley_collision_detector #(.STUCK_FRAMES(8)) dut (
    .clk                        (clk),
    .resetN                     (resetN),
    .startOfFrame               (startOfFrame),
    .pause                      (pause),
    .reset_level                (reset_level),
    .smileyDR                   (smileyDR),
    .borderTopDR                (borderTopDR),
    .borderLeftDR               (borderLeftDR),
    .borderRightDR              (borderRightDR),
    .flipperDR                  (flipperDR),
    .obstacleDR                 (obstacleDR),
    .obstacleHitEdgeCode        (obstacleHitEdgeCode),
    .collisionSmileyBorderTop   (colTop),
    .collisionSmileyBorderLeft  (colLeft),
    .collisionSmileyBorderRight (colRight),
    .collisionSmileyFlipper     (colFlipper),
    .collisionSmileyObstacle    (colObstacle),
    .hitEdgeCode                (hitEdgeCode),
    .frameCollisionMask         (frameCollisionMask),
    .stuckAlarm                 (stuckAlarm)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance n clock edges; inputs change and outputs are sampled 1 unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Set the overlap pattern for the current pixel: {obstacle, flipper, right, left, top}.
  task automatic applyStimulus(input logic [4:0] dr, input logic [3:0] code);
    smileyDR            = |dr;
    borderTopDR         = dr[0];
    borderLeftDR        = dr[1];
    borderRightDR       = dr[2];
    flipperDR           = dr[3];
    obstacleDR          = dr[4];
    obstacleHitEdgeCode = code;
  endtask

  task automatic frameEdge();
    startOfFrame = 1'b1;
    step(1);
    startOfFrame = 1'b0;
  endtask

  task automatic overlapOnce(input logic [4:0] dr, input logic [3:0] code);
    applyStimulus(dr, code);
    step(1);
    applyStimulus(5'b0, 4'b0);
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; pause = 1'b0; reset_level = 1'b0;
    applyStimulus(5'b0, 4'b0);
    #12;
    checkOutput("reset pulses", {3'b0, colObstacle, colFlipper, colRight, colLeft, colTop}, 8'h00);
    checkOutput("reset edge", {4'b0, hitEdgeCode}, 8'h00);
    checkOutput("reset mask", {3'b0, frameCollisionMask}, 8'h00);
    checkOutput("reset alarm", {7'b0, stuckAlarm}, 8'h00);
    step(1);
    resetN = 1'b1;
    step(2);

    // Two empty frames
    frameEdge(); step(4); frameEdge();
    checkOutput("idle mask", {3'b0, frameCollisionMask}, 8'h00);
    checkOutput("idle alarm", {7'b0, stuckAlarm}, 8'h00);

    // Top border held three cycles: one pulse
    step(3);
    applyStimulus(5'b00001, 4'b0);
    step(1);
    checkOutput("top pulse", {7'b0, colTop}, 8'h01);
    step(1);
    checkOutput("top pulse width 2", {7'b0, colTop}, 8'h00);
    step(1);
    checkOutput("top pulse width 3", {7'b0, colTop}, 8'h00);
    applyStimulus(5'b0, 4'b0);
    step(2);
    frameEdge();
    checkOutput("top mask", {3'b0, frameCollisionMask}, 8'h01);

    // Obstacle edge code capture
    step(2);
    overlapOnce(5'b10000, 4'b0100);
    checkOutput("obst pulse", {7'b0, colObstacle}, 8'h01);
    checkOutput("obst edge", {4'b0, hitEdgeCode}, 8'h04);
    step(2);
    overlapOnce(5'b10000, 4'b0001);
    checkOutput("obst second pulse", {7'b0, colObstacle}, 8'h00);
    checkOutput("obst edge held", {4'b0, hitEdgeCode}, 8'h04);
    frameEdge();
    checkOutput("obst mask", {3'b0, frameCollisionMask}, 8'h10);
    step(2);
    overlapOnce(5'b10000, 4'b0001);
    checkOutput("obst next frame pulse", {7'b0, colObstacle}, 8'h01);
    checkOutput("obst next frame edge", {4'b0, hitEdgeCode}, 8'h01);
    step(1);
    frameEdge();

    // Left border every frame for 8 frames
    for (int f = 1; f <= 8; f++) begin
      step(2);
      overlapOnce(5'b00010, 4'b0);
      if (f == 1) checkOutput("left pulse", {7'b0, colLeft}, 8'h01);
      step(2);
      frameEdge();
      if (f == 7) checkOutput("alarm after 7", {7'b0, stuckAlarm}, 8'h00);
    end
    checkOutput("alarm after 8", {7'b0, stuckAlarm}, 8'h01);
    checkOutput("stuck mask", {3'b0, frameCollisionMask}, 8'h02);
    step(4);
    frameEdge();
    checkOutput("alarm cleared", {7'b0, stuckAlarm}, 8'h00);

    // Pause holds the stuck count: 7 border frames, paused frame, then one more
    for (int f = 1; f <= 7; f++) begin
      step(2);
      overlapOnce(5'b00010, 4'b0);
      step(1);
      frameEdge();
    end
    pause = 1'b1;
    step(2);
    applyStimulus(5'b01000, 4'b0);
    step(1);
    checkOutput("paused flipper pulse", {7'b0, colFlipper}, 8'h00);
    step(2);
    checkOutput("paused flipper held", {7'b0, colFlipper}, 8'h00);
    applyStimulus(5'b0, 4'b0);
    frameEdge();
    checkOutput("paused sof mask", {3'b0, frameCollisionMask}, 8'h00);
    checkOutput("paused sof alarm", {7'b0, stuckAlarm}, 8'h00);
    step(2);
    pause = 1'b0;
    overlapOnce(5'b01000, 4'b0);
    checkOutput("unpause flipper pulse", {7'b0, colFlipper}, 8'h01);
    step(1);
    checkOutput("unpause flipper single", {7'b0, colFlipper}, 8'h00);
    overlapOnce(5'b00010, 4'b0);
    step(1);
    frameEdge();
    checkOutput("unpause mask", {3'b0, frameCollisionMask}, 8'h0A);
    checkOutput("alarm after held count", {7'b0, stuckAlarm}, 8'h01);

    // Overlap only on the frame-edge cycle
    step(3);
    applyStimulus(5'b00001, 4'b0);
    frameEdge();
    applyStimulus(5'b0, 4'b0);
    checkOutput("sof overlap pulse", {7'b0, colTop}, 8'h00);
    checkOutput("sof overlap mask", {3'b0, frameCollisionMask}, 8'h01);
    step(1);
    checkOutput("sof overlap late pulse", {7'b0, colTop}, 8'h00);

    // reset_level after obstacle pulse
    overlapOnce(5'b10000, 4'b1000);
    checkOutput("rl obst edge", {4'b0, hitEdgeCode}, 8'h08);
    reset_level = 1'b1;
    step(1);
    reset_level = 1'b0;
    checkOutput("rl edge", {4'b0, hitEdgeCode}, 8'h00);
    checkOutput("rl mask", {3'b0, frameCollisionMask}, 8'h00);
    checkOutput("rl alarm", {7'b0, stuckAlarm}, 8'h00);

    // reset_level together with startOfFrame wins
    step(2);
    overlapOnce(5'b00010, 4'b0);
    reset_level = 1'b1;
    frameEdge();
    reset_level = 1'b0;
    checkOutput("rl+sof mask", {3'b0, frameCollisionMask}, 8'h00);
    step(2);
    frameEdge();
    checkOutput("rl cleared seen", {3'b0, frameCollisionMask}, 8'h00);

    // Async reset mid-frame
    step(2);
    overlapOnce(5'b10100, 4'b0010);
    checkOutput("pre-reset pulses", {3'b0, colObstacle, colFlipper, colRight, colLeft, colTop}, 8'h14);
    frameEdge();
    #2 resetN = 1'b0;
    #1;
    checkOutput("async mask", {3'b0, frameCollisionMask}, 8'h00);
    checkOutput("async edge", {4'b0, hitEdgeCode}, 8'h00);
    step(1);
    resetN = 1'b1;
    step(1);
    overlapOnce(5'b00100, 4'b0);
    checkOutput("post-reset right pulse", {7'b0, colRight}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
